// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: shared types and sizing helpers for the
// synchronous instruction memory (state enum, defaults).
package instr_mem_pkg;

  typedef enum logic {
    IMEM_INIT,
    IMEM_RUN
  } imem_state_e;

  localparam int IMEM_DATA_W = 16;
  localparam int IMEM_DEPTH  = 256;

  // Index width for a memory of `depth` words, never below 1.
  function automatic int IMEM_IDX_W(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_sdp_ram.sv
// imem_sdp_ram: simple dual-port RAM, one write port and one
// registered read port (read-before-write on address collision).
// Ports: we/waddr/wdata write; re/rzero/raddr read, rdata out.
// rzero loads 0 instead of the array word (faulting fetch).
module imem_sdp_ram #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic              rzero,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The array is sampled before this edge's write lands,
  // so a colliding read returns the old word.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = rzero ? '0 : mem[raddr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_memory_sync.sv
// instr_memory_sync: registered instruction memory with zero-fill
// after reset, program-load port and valid/ready fetch handshake.
// Ports: req_* fetch request, resp_* response, ld_* load port,
// init_done high once zero-fill is complete.
// Optional INSTR_MEM_BOUNDS_EN: out-of-range fetches fault and
// out-of-range loads are dropped; otherwise addresses truncate.
module instr_memory_sync
  import instr_mem_pkg::*;
#(
  parameter int DATA_W = IMEM_DATA_W,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_fault,
  input  logic              ld_en,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              init_done
);

  localparam int IDX_W = IMEM_IDX_W(DEPTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  imem_state_e       state_q;
  imem_state_e       state_d;
  logic [IDX_W-1:0]  fill_ptr_q;
  logic [IDX_W-1:0]  fill_ptr_d;
  logic              resp_valid_q;
  logic              resp_valid_d;
  logic              resp_fault_q;
  logic              resp_fault_d;
  logic              req_oor;
  logic              ld_oor;
  logic              accept;
  logic              ram_we;
  logic [IDX_W-1:0]  ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

`ifdef INSTR_MEM_BOUNDS_EN
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  assign req_oor = {1'b0, req_addr} >= DEPTH_L;
  assign ld_oor  = {1'b0, ld_addr} >= DEPTH_L;
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr, ld_addr};
  assign req_oor = 1'b0;
  assign ld_oor  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    fill_ptr_d = fill_ptr_q;
    req_ready  = 1'b0;
    ld_ready   = 1'b0;
    init_done  = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = fill_ptr_q;
    ram_wdata  = '0;
    unique case (state_q)
      IMEM_INIT: begin
        ram_we     = 1'b1;
        fill_ptr_d = fill_ptr_q + 1'b1;
        if (fill_ptr_q == LAST) begin
          state_d = IMEM_RUN;
        end
      end
      IMEM_RUN: begin
        init_done = 1'b1;
        ld_ready  = 1'b1;
        // Pass-through ready: a draining slot can refill
        req_ready = !resp_valid_q || resp_ready;
        if (ld_en && !ld_oor) begin
          ram_we    = 1'b1;
          ram_waddr = ld_addr[IDX_W-1:0];
          ram_wdata = ld_data;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    accept       = req_valid && req_ready;
    resp_valid_d = resp_valid_q;
    resp_fault_d = resp_fault_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_fault_d = req_oor;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IMEM_INIT;
      fill_ptr_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_ptr_q   <= fill_ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  imem_sdp_ram #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (accept),
    .rzero (req_oor),
    .raddr (req_addr[IDX_W-1:0]),
    .rdata (resp_data)
  );

  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_instr_memory_sync.sv
// tb_instr_memory_sync: directed + random bench for the
// instruction memory against an array/transaction model.
module tb_instr_memory_sync;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic        resp_fault;
  logic        ld_en;
  logic        ld_ready;
  logic [15:0] ld_addr;
  logic [15:0] ld_data;
  logic        init_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem_m [DEPTH];
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_fault;

  always #5 clk = ~clk;

  instr_memory_sync dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_fault (resp_fault),
    .ld_en      (ld_en),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .init_done  (init_done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit in_range(input logic [15:0] a);
`ifdef INSTR_MEM_BOUNDS_EN
    return int'(a) < DEPTH;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    m_valid = 1'b0;
    m_data  = '0;
    m_fault = 1'b0;
  endtask

  task automatic drive(input bit rv, input logic [15:0] ra,
                       input bit rr, input bit le,
                       input logic [15:0] la,
                       input logic [15:0] ldv);
    req_valid  = rv;
    req_addr   = ra;
    resp_ready = rr;
    ld_en      = le;
    ld_addr    = la;
    ld_data    = ldv;
  endtask

  // One RUN cycle: check outputs, then advance the model.
  task automatic cycle();
    bit exp_rdy;
    #1;
    exp_rdy = !m_valid || resp_ready;
    chk("req_ready", req_ready, exp_rdy);
    chk("init_done", init_done, 1);
    chk("ld_ready", ld_ready, 1);
    chk("resp_valid", resp_valid, m_valid);
    if (m_valid) begin
      chk("resp_data", resp_data, m_data);
      chk("resp_fault", resp_fault, m_fault);
    end
    if (req_valid && exp_rdy) begin
      m_valid = 1'b1;
      if (in_range(req_addr)) begin
        m_data  = mem_m[int'(req_addr) % DEPTH];
        m_fault = 1'b0;
      end else begin
        m_data  = '0;
        m_fault = 1'b1;
      end
    end else if (resp_ready) begin
      m_valid = 1'b0;
    end
    if (ld_en && in_range(ld_addr))
      mem_m[int'(ld_addr) % DEPTH] = ld_data;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init();
    int n;
    bit rdy;
    n = 0;
    rdy = 1'b0;
    while (!init_done && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
      if (!init_done && (req_ready || ld_ready)) rdy = 1'b1;
    end
    chk("init_cycles", n, DEPTH);
    chk("ready_in_init", rdy, 0);
  endtask

  function automatic logic [15:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return 16'($urandom_range(0, 7));
    if (r < 8) return 16'($urandom_range(0, DEPTH - 1));
    return 16'($urandom);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 1, 0, 0, 0);
    model_clear();
    #3;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_fault", resp_fault, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_init_done", init_done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_init();

    // Fetch of last word after zero-fill
    drive(1, 16'h00FF, 1, 0, 0, 0); cycle();
    drive(0, 0, 1, 0, 0, 0); cycle();

    // Load then fetch next cycle
    drive(0, 0, 1, 1, 16'd5, 16'h1234); cycle();
    drive(1, 16'd5, 1, 0, 0, 0); cycle();
    drive(0, 0, 1, 0, 0, 0); cycle();

    // Back-to-back fetches
    drive(0, 0, 1, 1, 16'd0, 16'hA000); cycle();
    drive(0, 0, 1, 1, 16'd1, 16'hA001); cycle();
    drive(0, 0, 1, 1, 16'd2, 16'hA002); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'(i), 1, 0, 0, 0); cycle();
    end
    drive(0, 0, 1, 0, 0, 0); cycle();

    // Backpressure for 3 cycles, then release
    drive(1, 16'd1, 1, 0, 0, 0); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'd2, 0, 0, 0, 0); cycle();
    end
    drive(1, 16'd2, 1, 0, 0, 0); cycle();
    drive(0, 0, 1, 0, 0, 0); cycle();
    drive(0, 0, 1, 0, 0, 0); cycle();

    // Same-cycle load and fetch of one address
    drive(1, 16'd3, 1, 1, 16'd3, 16'h5A5A); cycle();
    drive(1, 16'd3, 1, 0, 0, 0); cycle();
    drive(0, 0, 1, 0, 0, 0); cycle();

    // Address just past the end
    drive(1, 16'h0100, 1, 0, 0, 0); cycle();
    drive(0, 0, 1, 1, 16'h0100, 16'hDEAD); cycle();
    drive(1, 16'h0000, 1, 0, 0, 0); cycle();
    drive(0, 0, 1, 0, 0, 0); cycle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, rnd_addr(),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, rnd_addr(),
            16'($urandom));
      cycle();
    end

    // Reset with a response pending
    drive(0, 0, 1, 1, 16'd5, 16'hBEEF); cycle();
    drive(1, 16'd5, 1, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0); cycle();
    chk("pend_valid", resp_valid, 1);
    chk("pend_data", resp_data, 16'hBEEF);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_data", resp_data, 0);
    chk("mid_rst_init_done", init_done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 0, 1, 0, 0, 0);
    model_clear();
    wait_init();
    drive(1, 16'd5, 1, 0, 0, 0); cycle();
    drive(0, 0, 1, 0, 0, 0); cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
